// File: rtl/daq_pkg.sv
// Shared types and constants for the multi-channel DAQ capture master.
package daq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_BUS  = 2'd2
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [3:0] SEL_ALL     = 4'hF;

  // Width of an index able to address n items (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/daq_capture_mc_if.sv
// Wishbone classic master bundle used by the DAQ capture master.
interface daq_capture_mc_if #(
  parameter int unsigned AW = 32
) ();

  logic [AW-1:0] adr_o;
  logic [31:0]   dat_o;
  logic [31:0]   dat_i;
  logic [3:0]    sel_o;
  logic          we_o;
  logic          cyc_o;
  logic          stb_o;
  logic [2:0]    cti_o;
  logic [1:0]    bte_o;
  logic          ack_i;
  logic          err_i;
  logic          rty_i;

  modport master (
    output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, cti_o, bte_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, cti_o, bte_o,
    output dat_i, ack_i, err_i, rty_i
  );

endinterface

// File: rtl/daq_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr.
module daq_rr_arbiter
  import daq_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CW     = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CW-1:0]     gnt_idx
);

  // Scan channels starting from the pointer, wrapping modulo NUM_CH.
  always_comb begin
    logic        found;
    int unsigned k;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      k = (32'(ptr) + i) % NUM_CH;
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = CW'(k);
      end
    end
  end

endmodule

// File: rtl/daq_capture_mc.sv
// Multi-channel DAQ capture: per-channel holding registers drained round-robin
// as single Wishbone classic writes into per-channel RAM buffers.
module daq_capture_mc
  import daq_pkg::*;
#(
  parameter int unsigned   NUM_CH    = 4,
  parameter int unsigned   SAMPLE_W  = 16,
  parameter int unsigned   DEPTH     = 1024,
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         circular,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            smp_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   smp_data,
  daq_capture_mc_if.master             wb_m,
  output logic                         active,
  output logic                         done,
  output logic                         error,
  output logic [NUM_CH-1:0]            overrun,
  output logic [NUM_CH-1:0]            wrapped
);

  localparam int unsigned CW = idx_w(NUM_CH);
  localparam int unsigned XW = $clog2(DEPTH) + 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       ptr_q, cur_q, issue_ch, gnt_idx;
  logic                retry_q, stop_q, circ_q;
  logic [NUM_CH-1:0]   en_q, full_q, cmpl, req, gnt, capture, freed;
  logic [SAMPLE_W-1:0] hold_q [NUM_CH];
  logic [XW-1:0]       idx_q  [NUM_CH];
  logic                gnt_any, all_done;
  logic                start_acc, issue, take, to_idle, set_done, set_err, retry_set;

  // Per-channel status: completion, pending requests, accepted samples, freed holds.
  always_comb begin
    cmpl    = '0;
    capture = '0;
    freed   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cmpl[c]    = !circ_q && (idx_q[c] == XW'(DEPTH));
      capture[c] = (state_q != ST_IDLE) && en_q[c] && !cmpl[c] && smp_valid[c];
      freed[c]   = take && (cur_q == CW'(c));
    end
    req      = full_q & en_q & ~cmpl;
    all_done = ((en_q & ~cmpl) == '0);
  end

  daq_rr_arbiter #(.NUM_CH(NUM_CH), .CW(CW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_any = |gnt;

  // FSM state register.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // FSM next state and control strobes.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    issue     = 1'b0;
    issue_ch  = cur_q;
    take      = 1'b0;
    to_idle   = 1'b0;
    set_done  = 1'b0;
    set_err   = 1'b0;
    retry_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = ST_ARB;
        end
      end
      ST_ARB: begin
        if (stop || (!retry_q && all_done)) begin
          to_idle  = 1'b1;
          set_done = 1'b1;
        end else if (retry_q) begin
          issue   = 1'b1;
          state_d = ST_BUS;
        end else if (gnt_any) begin
          issue    = 1'b1;
          issue_ch = gnt_idx;
          state_d  = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wb_m.ack_i) begin
          take = 1'b1;
          if (stop || stop_q) begin
            to_idle  = 1'b1;
            set_done = 1'b1;
          end else begin
            state_d = ST_ARB;
          end
        end else if (wb_m.err_i) begin
          to_idle = 1'b1;
          set_err = 1'b1;
        end else if (wb_m.rty_i) begin
          if (stop || stop_q) begin
            to_idle  = 1'b1;
            set_done = 1'b1;
          end else begin
            retry_set = 1'b1;
            state_d   = ST_ARB;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (to_idle) state_d = ST_IDLE;
  end

  // Registered Wishbone outputs; held stable for the whole transfer.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb_m.adr_o <= '0;
      wb_m.dat_o <= '0;
      wb_m.sel_o <= '0;
      wb_m.we_o  <= 1'b0;
      wb_m.cyc_o <= 1'b0;
      wb_m.stb_o <= 1'b0;
      wb_m.cti_o <= '0;
      wb_m.bte_o <= '0;
    end else if (issue) begin
      wb_m.adr_o <= BASE_ADDR +
                    ((AW'(issue_ch) * AW'(DEPTH) + AW'(idx_q[issue_ch])) << 2);
      wb_m.dat_o <= 32'(hold_q[issue_ch]);
      wb_m.sel_o <= SEL_ALL;
      wb_m.we_o  <= 1'b1;
      wb_m.cyc_o <= 1'b1;
      wb_m.stb_o <= 1'b1;
      wb_m.cti_o <= CTI_CLASSIC;
      wb_m.bte_o <= BTE_LINEAR;
    end else if ((state_q == ST_BUS) && (wb_m.ack_i || wb_m.err_i || wb_m.rty_i)) begin
      wb_m.cyc_o <= 1'b0;
      wb_m.stb_o <= 1'b0;
    end
  end

  // Capture configuration, arbiter pointer, retry/stop bookkeeping and status.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ptr_q   <= '0;
      cur_q   <= '0;
      retry_q <= 1'b0;
      stop_q  <= 1'b0;
      circ_q  <= 1'b0;
      en_q    <= '0;
      active  <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      if (issue) cur_q <= issue_ch;
      if (take)  ptr_q <= (cur_q == CW'(NUM_CH - 1)) ? '0 : cur_q + CW'(1);
      if (retry_set)            retry_q <= 1'b1;
      else if (issue || to_idle) retry_q <= 1'b0;
      if (start_acc || to_idle)            stop_q <= 1'b0;
      else if ((state_q == ST_BUS) && stop) stop_q <= 1'b1;
      if (start_acc) begin
        circ_q <= circular;
        en_q   <= ch_enable;
        active <= 1'b1;
        done   <= 1'b0;
        error  <= 1'b0;
      end
      if (to_idle) begin
        active <= 1'b0;
        if (set_done) done  <= 1'b1;
        if (set_err)  error <= 1'b1;
      end
    end
  end

  // Per-channel holding registers, sample indices and sticky flags.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      full_q  <= '0;
      overrun <= '0;
      wrapped <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        hold_q[c] <= '0;
        idx_q[c]  <= '0;
      end
    end else if (start_acc) begin
      full_q  <= '0;
      overrun <= '0;
      wrapped <= '0;
      for (int c = 0; c < NUM_CH; c++) idx_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (freed[c]) begin
          full_q[c] <= 1'b0;
          if (circ_q && (idx_q[c] == XW'(DEPTH - 1))) begin
            idx_q[c]   <= '0;
            wrapped[c] <= 1'b1;
          end else begin
            idx_q[c] <= idx_q[c] + XW'(1);
          end
        end
        if (capture[c]) begin
          if (!full_q[c] || freed[c]) begin
            hold_q[c] <= smp_data[c*SAMPLE_W +: SAMPLE_W];
            full_q[c] <= 1'b1;
          end else begin
            overrun[c] <= 1'b1;
          end
        end
      end
      if (to_idle) full_q <= '0;
    end
  end

endmodule

// File: tb/tb_daq_capture_mc.sv
// Bench for daq_capture_mc: vector table, directed corner sequences and a
// randomized circular run checked against per-channel sample queues.
module tb_daq_capture_mc;

  localparam int unsigned NCH  = 4;
  localparam int unsigned SW   = 16;
  localparam int unsigned DEP  = 1024;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int K_ACK = 0;
  localparam int K_RTY = 1;
  localparam int K_ERR = 2;

  logic              wb_clk = 1'b0;
  logic              wb_rst_n = 1'b0;
  logic              start, stop, circular;
  logic [NCH-1:0]    ch_enable, smp_valid;
  logic [NCH*SW-1:0] smp_data;
  logic              active, done, error;
  logic [NCH-1:0]    overrun, wrapped;

  daq_capture_mc_if #(.AW(32)) wb ();

  daq_capture_mc #(
    .NUM_CH(NCH), .SAMPLE_W(SW), .DEPTH(DEP), .AW(32), .BASE_ADDR(BASE)
  ) dut (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .start     (start),
    .stop      (stop),
    .circular  (circular),
    .ch_enable (ch_enable),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .wb_m      (wb),
    .active    (active),
    .done      (done),
    .error     (error),
    .overrun   (overrun),
    .wrapped   (wrapped)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    int          kind;
    logic [31:0] adr;
    logic [31:0] dat;
  } resp_t;

  typedef struct {
    logic [3:0]  en;
    int          ch;
    logic [15:0] d;
    bit          wr;
    logic [31:0] adr;
    logic [31:0] dat;
  } vec_t;

  typedef logic [15:0] q16_t [$];

  resp_t resp_q [$];
  int    tests = 0;
  int    fails = 0;
  int    next_resp = K_ACK;
  bit    resp_en = 1'b1;
  bit    rand_delay = 1'b0;
  int    ack_delay = 0;
  bit    busy = 1'b0;
  int    wcnt = 0;
  int    cur_delay = 0;

  // Wishbone slave: responds after a programmable wait, logging every response.
  initial begin
    wb.ack_i = 1'b0;
    wb.err_i = 1'b0;
    wb.rty_i = 1'b0;
    wb.dat_i = '0;
    forever begin
      @(negedge wb_clk);
      wb.ack_i = 1'b0;
      wb.err_i = 1'b0;
      wb.rty_i = 1'b0;
      if (!(wb_rst_n && wb.cyc_o && wb.stb_o)) begin
        busy = 1'b0;
      end else if (resp_en) begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = 0;
          cur_delay = rand_delay ? int'($urandom_range(0, 2)) : ack_delay;
        end
        if (wcnt < cur_delay) begin
          wcnt++;
        end else begin
          case (next_resp)
            K_RTY:   wb.rty_i = 1'b1;
            K_ERR:   wb.err_i = 1'b1;
            default: wb.ack_i = 1'b1;
          endcase
          resp_q.push_back('{next_resp, wb.adr_o, wb.dat_o});
          next_resp = K_ACK;
          busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_resp(input string name, input int n, input int budget);
    for (int i = 0; i < budget && resp_q.size() < n; i++) @(posedge wb_clk);
    chk(name, 32'(resp_q.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    wb_rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    smp_valid = '0;
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
  endtask

  task automatic pulse_start(input bit circ, input logic [3:0] en);
    @(negedge wb_clk);
    start = 1'b1;
    circular = circ;
    ch_enable = en;
    @(negedge wb_clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge wb_clk);
    stop = 1'b1;
    @(negedge wb_clk);
    stop = 1'b0;
    @(negedge wb_clk);
  endtask

  task automatic send(input int ch, input logic [15:0] d);
    @(negedge wb_clk);
    smp_valid[ch] = 1'b1;
    smp_data[ch*SW +: SW] = d;
    @(negedge wb_clk);
    smp_valid = '0;
  endtask

  vec_t vecs [6];

  initial begin
    int   bad;
    int   sent;
    int   gap [NCH];
    int   wcount [NCH];
    q16_t expq [NCH];

    vecs[0] = '{4'b0001, 0, 16'hA5A5, 1'b1, 32'h1000_0000, 32'h0000_A5A5};
    vecs[1] = '{4'b0010, 1, 16'hFFFF, 1'b1, 32'h1000_1000, 32'h0000_FFFF};
    vecs[2] = '{4'b0100, 2, 16'h1234, 1'b1, 32'h1000_2000, 32'h0000_1234};
    vecs[3] = '{4'b1000, 3, 16'h8001, 1'b1, 32'h1000_3000, 32'h0000_8001};
    vecs[4] = '{4'b1111, 3, 16'h0000, 1'b1, 32'h1000_3000, 32'h0000_0000};
    vecs[5] = '{4'b0001, 2, 16'h5555, 1'b0, 32'h0,         32'h0};

    circular = 1'b0;
    ch_enable = '0;
    smp_data = '0;
    do_reset();

    // Reset state.
    chk("rst_ctl", 32'({wb.cyc_o, wb.stb_o, wb.we_o, wb.sel_o, wb.cti_o, wb.bte_o}), 32'd0);
    chk("rst_adr", wb.adr_o, 32'd0);
    chk("rst_dat", wb.dat_o, 32'd0);
    chk("rst_status", 32'({active, done, error, overrun, wrapped}), 32'd0);

    // No channel enabled: finishes the cycle after start.
    pulse_start(1'b0, 4'b0000);
    chk("noch_active_start", 32'(active), 32'd1);
    @(negedge wb_clk);
    chk("noch_done", 32'(done), 32'd1);
    chk("noch_active", 32'(active), 32'd0);

    // Single-sample table: address/data mapping, disabled-channel filtering, stop.
    for (int v = 0; v < 6; v++) begin
      resp_q.delete();
      pulse_start(1'b0, vecs[v].en);
      send(vecs[v].ch, vecs[v].d);
      if (vecs[v].wr) begin
        wait_resp($sformatf("tbl%0d_wait", v), 1, 30);
        if (resp_q.size() > 0) begin
          chk($sformatf("tbl%0d_adr", v), resp_q[0].adr, vecs[v].adr);
          chk($sformatf("tbl%0d_dat", v), resp_q[0].dat, vecs[v].dat);
        end
      end else begin
        repeat (10) @(negedge wb_clk);
        chk($sformatf("tbl%0d_nowrite", v), 32'(resp_q.size()), 32'd0);
      end
      pulse_stop();
      chk($sformatf("tbl%0d_done", v), 32'({done, active}), 32'b10);
    end
    chk("tbl_bus_fixed", 32'({wb.sel_o, wb.we_o, wb.cti_o, wb.bte_o}), 32'({4'hF, 1'b1, 3'b000, 2'b00}));

    // One-shot ch2, full buffer.
    resp_q.delete();
    pulse_start(1'b0, 4'b0100);
    for (int i = 0; i < int'(DEP); i++) begin
      send(2, 16'(i));
      wait_resp("os_wait", i + 1, 20);
    end
    bad = 0;
    for (int i = 0; i < resp_q.size(); i++)
      if (resp_q[i].adr !== BASE + 32'h2000 + 32'(4 * i) || resp_q[i].dat !== 32'(i)) bad++;
    chk("os_seq_errors", 32'(bad), 32'd0);
    chk("os_first_adr", resp_q[0].adr, 32'h1000_2000);
    chk("os_last_adr", resp_q[resp_q.size()-1].adr, 32'h1000_2FFC);
    for (int i = 0; i < 20 && !done; i++) @(negedge wb_clk);
    chk("os_done", 32'({done, active}), 32'b10);
    chk("os_overrun", 32'(overrun), 32'd0);
    send(2, 16'h7);
    repeat (5) @(negedge wb_clk);
    chk("os_no_extra", 32'(resp_q.size()), 32'(DEP));

    // Circular ch0, wraps after DEPTH samples.
    resp_q.delete();
    pulse_start(1'b1, 4'b0001);
    for (int i = 0; i < 1030; i++) begin
      send(0, 16'(i));
      wait_resp("circ_wait", i + 1, 20);
    end
    if (resp_q.size() >= 1030) begin
      chk("circ_adr1023", resp_q[1023].adr, 32'h1000_0FFC);
      chk("circ_adr1024", resp_q[1024].adr, 32'h1000_0000);
      chk("circ_dat1024", resp_q[1024].dat, 32'd1024);
      chk("circ_adr1029", resp_q[1029].adr, 32'h1000_0014);
    end
    chk("circ_wrapped", 32'(wrapped), 32'b0001);
    chk("circ_running", 32'({done, active}), 32'b01);
    pulse_stop();
    chk("circ_stop", 32'({done, active, wrapped}), 32'({2'b10, 4'b0001}));

    // All channels at once, slow acks, overrun on ch3 only.
    do_reset();
    ack_delay = 3;
    resp_q.delete();
    pulse_start(1'b0, 4'b1111);
    @(negedge wb_clk);
    smp_valid = 4'hF;
    for (int c = 0; c < int'(NCH); c++) smp_data[c*SW +: SW] = 16'h00A0 + 16'(c);
    @(negedge wb_clk);
    smp_valid = '0;
    repeat (2) @(negedge wb_clk);
    send(3, 16'hDEAD);
    wait_resp("rr_wait", 4, 100);
    if (resp_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rr_adr%0d", i), resp_q[i].adr, BASE + 32'(i * 32'h1000));
        chk($sformatf("rr_dat%0d", i), resp_q[i].dat, 32'h00A0 + 32'(i));
      end
    end
    chk("rr_overrun", 32'(overrun), 32'b1000);
    pulse_stop();
    ack_delay = 0;

    // Retry: same write re-issued after one idle cycle.
    resp_q.delete();
    pulse_start(1'b0, 4'b0010);
    next_resp = K_RTY;
    send(1, 16'h0BEE);
    wait_resp("rty_wait1", 1, 20);
    if (resp_q.size() >= 1) chk("rty_kind", 32'(resp_q[0].kind), 32'(K_RTY));
    @(negedge wb_clk);
    chk("rty_idle", 32'({wb.cyc_o, wb.stb_o}), 32'b00);
    @(negedge wb_clk);
    chk("rty_reissue", 32'({wb.cyc_o, wb.stb_o}), 32'b11);
    wait_resp("rty_wait2", 2, 20);
    if (resp_q.size() >= 2) begin
      chk("rty_ack_kind", 32'(resp_q[1].kind), 32'(K_ACK));
      chk("rty_adr", resp_q[1].adr, 32'h1000_1000);
      chk("rty_dat", resp_q[1].dat, 32'h0000_0BEE);
    end
    send(1, 16'h0C0D);
    wait_resp("rty_wait3", 3, 20);
    if (resp_q.size() >= 3) chk("rty_next_adr", resp_q[2].adr, 32'h1000_1004);
    pulse_stop();

    // Bus error aborts capture; next start clears the flag.
    resp_q.delete();
    pulse_start(1'b0, 4'b0010);
    next_resp = K_ERR;
    send(1, 16'h0E0E);
    wait_resp("err_wait", 1, 20);
    @(negedge wb_clk);
    chk("err_flags", 32'({error, active, done, wb.cyc_o}), 32'b1000);
    pulse_start(1'b0, 4'b0010);
    chk("err_cleared", 32'({error, active}), 32'b01);
    pulse_stop();

    // Asynchronous reset during an outstanding transfer.
    resp_en = 1'b0;
    resp_q.delete();
    pulse_start(1'b0, 4'b0001);
    send(0, 16'h1111);
    for (int i = 0; i < 20 && !wb.cyc_o; i++) @(negedge wb_clk);
    chk("arst_pre_cyc", 32'(wb.cyc_o), 32'd1);
    #2 wb_rst_n = 1'b0;
    #1;
    chk("arst_ctl", 32'({wb.cyc_o, wb.stb_o, wb.we_o, wb.sel_o, active, done, error, overrun, wrapped}), 32'd0);
    chk("arst_adr", wb.adr_o, 32'd0);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    resp_en = 1'b1;
    pulse_start(1'b0, 4'b0001);
    send(0, 16'h7777);
    wait_resp("arst_wait", 1, 20);
    if (resp_q.size() >= 1) begin
      chk("arst_adr_after", resp_q[0].adr, 32'h1000_0000);
      chk("arst_dat_after", resp_q[0].dat, 32'h0000_7777);
    end
    pulse_stop();

    // Randomized circular run, per-channel in-order delivery.
    resp_q.delete();
    rand_delay = 1'b1;
    sent = 0;
    for (int c = 0; c < int'(NCH); c++) begin
      gap[c] = 0;
      wcount[c] = 0;
      expq[c].delete();
    end
    pulse_start(1'b1, 4'b1111);
    for (int t = 0; t < 2000; t++) begin
      @(negedge wb_clk);
      smp_valid = '0;
      for (int c = 0; c < int'(NCH); c++) begin
        if (gap[c] > 0) begin
          gap[c]--;
        end else if ($urandom_range(0, 1) == 1) begin
          logic [15:0] d;
          d = 16'($urandom);
          smp_valid[c] = 1'b1;
          smp_data[c*SW +: SW] = d;
          expq[c].push_back(d);
          gap[c] = 24 + int'($urandom_range(0, 7));
          sent++;
        end
      end
    end
    @(negedge wb_clk);
    smp_valid = '0;
    wait_resp("rnd_drain", sent, 300);
    chk("rnd_count", 32'(resp_q.size()), 32'(sent));
    chk("rnd_overrun", 32'(overrun), 32'd0);
    bad = 0;
    foreach (resp_q[i]) begin
      logic [31:0] off;
      int          c;
      off = resp_q[i].adr - BASE;
      c = int'(off >> 12);
      if (c >= int'(NCH) || expq[c].size() == 0) begin
        bad++;
      end else begin
        if (off[11:2] !== 10'(wcount[c] % int'(DEP))) bad++;
        if (resp_q[i].dat !== 32'(expq[c].pop_front())) bad++;
        wcount[c]++;
      end
    end
    chk("rnd_model_errors", 32'(bad), 32'd0);
    pulse_stop();
    chk("rnd_stop", 32'({done, active}), 32'b10);
    rand_delay = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
